// File: rtl/ps2_scan_sequencer.sv
// ============================================================================
// Module   : ps2_scan_sequencer
// Brief    : PS/2 receive sequencer: frame FSM with timeout, E0/F0 prefix
//            folding and a first-word-fall-through key-event FIFO.
//            Optional build macro: PS2_PARITY_CHECK_EN (enforce odd parity).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_sequencer #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_extended,
    output logic       frame_err,
    output logic       overflow
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TO_W-1:0]  c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]        r_state;
    logic              r_ps2_clk_q;
    logic [2:0]        r_bit_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_shreg;
    logic              r_parity;
    logic              r_byte_valid;
    logic [7:0]        r_byte_q;
    logic              r_frame_err;

    logic              w_fall;
    logic              w_parity_odd;
    logic              w_parity_ok;

    assign w_fall       = r_ps2_clk_q & ~ps2_clk;
    assign w_parity_odd = ^{r_shreg, r_parity};

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = w_parity_odd;
`else
    // Parity is still captured, but only the stop bit qualifies the frame.
    assign w_parity_ok = w_parity_odd | 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ps2_clk_q  <= 1'b1;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_shreg      <= '0;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_q     <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_ps2_clk_q  <= ps2_clk;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_fall || r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (!w_fall && r_state != S_IDLE && r_to_cnt == c_TO_MAX) begin
                // Abandon the partial frame; prefix flags live downstream and are untouched.
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!ps2_data) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shreg   <= {ps2_data, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= ps2_data;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        if (ps2_data && w_parity_ok) begin
                            r_byte_valid <= 1'b1;
                            r_byte_q     <= r_shreg;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    logic                r_ext_f;
    logic                r_brk_f;
    logic [9:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    logic                w_is_e0;
    logic                w_is_f0;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_wr_en;
    logic [9:0]          w_head;

    assign w_is_e0 = (r_byte_q == 8'hE0);
    assign w_is_f0 = (r_byte_q == 8'hF0);
    assign w_push  = r_byte_valid & ~w_is_e0 & ~w_is_f0;
    assign w_pop   = ev_valid & ev_ready;
    assign w_full  = (r_count == c_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext_f    <= 1'b0;
            r_brk_f    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;

            if (r_byte_valid) begin
                if (w_is_e0) begin
                    r_ext_f <= 1'b1;
                end else if (w_is_f0) begin
                    r_brk_f <= 1'b1;
                end else begin
                    r_ext_f <= 1'b0;
                    r_brk_f <= 1'b0;
                end
            end

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {r_byte_q, r_brk_f, r_ext_f};
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign ev_valid    = (r_count != '0);
    assign ev_code     = ev_valid ? w_head[9:2] : 8'h00;
    assign ev_break    = ev_valid & w_head[1];
    assign ev_extended = ev_valid & w_head[0];
    assign frame_err   = r_frame_err;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_sequencer.sv
// ============================================================================
// Module   : tb_ps2_scan_sequencer
// Brief    : Scoreboard bench for ps2_scan_sequencer (framing, prefixes,
//            errors, timeout, FIFO overflow, mid-frame reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scan_sequencer;

    localparam int c_TIMEOUT = 5000;
    localparam int c_DEPTH   = 4;
    localparam int c_HALF    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ev_ready;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_extended;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_scan_sequencer #(
        .TIMEOUT_CYCLES(c_TIMEOUT),
        .FIFO_DEPTH    (c_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_break   (ev_break),
        .ev_extended(ev_extended),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;

    // Event monitor: compares every accepted event against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overflow)  ov_cnt++;
            if (ev_valid && ev_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event: got code=%h brk=%b ext=%b, required no event",
                             ev_code, ev_break, ev_extended);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({ev_code, ev_break, ev_extended} !== mon_exp) begin
                        n_errors++;
                        $display("FAIL event: got code=%h brk=%b ext=%b, required code=%h brk=%b ext=%b",
                                 ev_code, ev_break, ev_extended, mon_exp[9:2], mon_exp[1], mon_exp[0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b, input bit last);
        ps2_data = b;
        step(c_HALF);
        ps2_clk = 1'b0;
        if (!last) begin
            step(c_HALF);
            ps2_clk = 1'b1;
        end
    endtask

    // Leaves ps2_clk low right after the stop-bit falling edge.
    task automatic frame_raw(input logic [7:0] code, input bit bad_par, input logic stop);
        logic par;
        par = (~^code) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, 1'b1);
    endtask

    task automatic frame_tail();
        step(c_HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(c_HALF * 2);
    endtask

    task automatic model_byte(input logic [7:0] code, input bit bad_par, input logic stop);
        bit ok;
        ok = (stop == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        if (bad_par) ok = 1'b0;
`endif
        if (ok) begin
            if (code == 8'hE0) m_ext = 1'b1;
            else if (code == 8'hF0) m_brk = 1'b1;
            else begin
                if (exp_q.size() < c_DEPTH) exp_q.push_back({code, m_brk, m_ext});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] code, input bit bad_par, input logic stop);
        model_byte(code, bad_par, stop);
        frame_raw(code, bad_par, stop);
        frame_tail();
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || ev_valid); i++) step(1);
        n_checks++;
        if (exp_q.size() != 0 || ev_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_drain: got pending=%0d ev_valid=%b, required pending=0 ev_valid=0",
                     name, exp_q.size(), ev_valid);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ev_ready = 1'b0;
        step(3);
        n_checks++;
        if ({ev_valid, ev_code, ev_break, ev_extended, frame_err, overflow} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {ev_valid, ev_code, ev_break, ev_extended, frame_err, overflow});
        end
        reset = 1'b0;
        step(2);
        n_checks++;
        if ({ev_valid, ev_code, ev_break, ev_extended, frame_err, overflow} !== 13'd0) begin
            n_errors++;
            $display("FAIL post_reset_outputs: got %b, required all zero",
                     {ev_valid, ev_code, ev_break, ev_extended, frame_err, overflow});
        end
        begin
            int fe0;
            fe0 = fe_cnt;
            step(10000);
            n_checks++;
            if (fe_cnt != fe0 || ev_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_quiet: got frame_err=%0d ev_valid=%b, required 0 and 0",
                         fe_cnt - fe0, ev_valid);
            end
        end
    endtask

    task automatic test_make();
        ev_ready = 1'b0;
        model_byte(8'h1C, 1'b0, 1'b1);
        frame_raw(8'h1C, 1'b0, 1'b1);
        step(1);
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL make_latency_n1: got ev_valid=%b, required 0", ev_valid);
        end
        step(1);
        n_checks++;
        if ({ev_valid, ev_code, ev_break, ev_extended} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL make_head_n2: got valid=%b code=%h brk=%b ext=%b, required 1 1c 0 0",
                     ev_valid, ev_code, ev_break, ev_extended);
        end
        frame_tail();
        drain("make");
        n_checks++;
        if (ev_code !== 8'h00) begin
            n_errors++;
            $display("FAIL make_empty_code: got %h, required 00", ev_code);
        end
    endtask

    task automatic test_prefix();
        ev_ready = 1'b1;
        send_byte(8'hE0, 1'b0, 1'b1);
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL prefix_e0_silent: got ev_valid=%b, required 0", ev_valid);
        end
        send_byte(8'hF0, 1'b0, 1'b1);
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL prefix_f0_silent: got ev_valid=%b, required 0", ev_valid);
        end
        send_byte(8'h75, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        drain("prefix");
    endtask

    task automatic test_bad_frames();
        int fe0;
        int fe_exp;
        ev_ready = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        fe_exp = 1;
`else
        fe_exp = 0;
`endif
        fe0 = fe_cnt;
        send_byte(8'h1C, 1'b1, 1'b1);
        n_checks++;
        if (fe_cnt - fe0 != fe_exp) begin
            n_errors++;
            $display("FAIL bad_parity_err: got %0d pulses, required %0d", fe_cnt - fe0, fe_exp);
        end
        drain("bad_parity");
        fe0 = fe_cnt;
        send_byte(8'h1C, 1'b0, 1'b0);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_errors++;
            $display("FAIL bad_stop_err: got %0d pulses, required 1", fe_cnt - fe0);
        end
        drain("bad_stop");
    endtask

    task automatic test_timeout();
        int fe0;
        ev_ready = 1'b1;
        send_byte(8'hE0, 1'b0, 1'b1);
        fe0 = fe_cnt;
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b1);
        step(c_HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(c_TIMEOUT - 200);
        n_checks++;
        if (fe_cnt != fe0) begin
            n_errors++;
            $display("FAIL timeout_early: got %0d pulses, required 0", fe_cnt - fe0);
        end
        step(400);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_errors++;
            $display("FAIL timeout_err: got %0d pulses, required 1", fe_cnt - fe0);
        end
        send_byte(8'h1C, 1'b0, 1'b1);
        drain("timeout");
    endtask

    task automatic test_overflow();
        int ov0;
        ev_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b1);
        n_checks++;
        if (ov_cnt - ov0 != 1) begin
            n_errors++;
            $display("FAIL overflow_pulse: got %0d pulses, required 1", ov_cnt - ov0);
        end
        n_checks++;
        if (ev_valid !== 1'b1 || ev_code !== 8'h01) begin
            n_errors++;
            $display("FAIL overflow_head: got valid=%b code=%h, required 1 01", ev_valid, ev_code);
        end
        frame_raw(8'h06, 1'b0, 1'b1);
        step(1);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        exp_q.push_back({8'h06, 2'b00});
        frame_tail();
        n_checks++;
        if (ov_cnt - ov0 != 1) begin
            n_errors++;
            $display("FAIL full_push_pop_ovf: got %0d pulses, required 1", ov_cnt - ov0);
        end
        n_checks++;
        if (ev_valid !== 1'b1 || ev_code !== 8'h02) begin
            n_errors++;
            $display("FAIL full_push_pop_head: got valid=%b code=%h, required 1 02", ev_valid, ev_code);
        end
        drain("overflow");
    endtask

    task automatic test_reset_midframe();
        ev_ready = 1'b0;
        send_byte(8'h33, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, 1'b1);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b1);
        reset = 1'b1;
        step(2);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(1);
        reset = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        step(2);
        n_checks++;
        if (ev_valid !== 1'b0 || ev_code !== 8'h00) begin
            n_errors++;
            $display("FAIL midframe_reset_empty: got valid=%b code=%h, required 0 00", ev_valid, ev_code);
        end
        ev_ready = 1'b1;
        send_byte(8'h1C, 1'b0, 1'b1);
        drain("midframe_reset");
    endtask

    initial begin
        test_reset();
        test_make();
        test_prefix();
        test_bad_frames();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
